// File: rtl/mem_access.sv
// Memory-stage access controller: turns LD/ST at the EX/MEM boundary into a
// single-outstanding req/ack transaction with alignment and timeout checks.
module mem_access #(
  parameter int unsigned TIMEOUT   = 15,
  parameter logic [5:0]  OPCODE_LD = 6'h23,
  parameter logic [5:0]  OPCODE_ST = 6'h2b
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic        dm_err,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic [31:0] mem_out,
  output logic        mem_valid,
  output logic        mem_fault,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FAULT = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        dm_req_q, dm_req_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic [31:0] mem_out_q, mem_out_d;
  logic        mem_valid_q, mem_valid_d;
  logic        mem_fault_q, mem_fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  logic       memop;
  logic       mis;
  logic [7:0] cnt_inc;

  assign memop   = ex_valid && (opcode == OPCODE_LD || opcode == OPCODE_ST);
  assign mis     = (addr[1:0] != 2'b00);
  assign cnt_inc = cnt_q + 8'd1;

  // The upstream hold must never assert while the block sits in reset.
  assign stall = rst_n &&
                 (((state_q == IDLE) && memop && !mis) ||
                  ((state_q == BUSY) && !dm_ack));

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    dm_req_d     = dm_req_q;
    dm_we_d      = dm_we_q;
    dm_addr_d    = dm_addr_q;
    dm_wdata_d   = dm_wdata_q;
    mem_out_d    = mem_out_q;
    mem_valid_d  = 1'b0;
    mem_fault_d  = 1'b0;
    fault_addr_d = fault_addr_q;

    case (state_q)
      IDLE: begin
        if (memop) begin
          if (mis) begin
            fault_addr_d = addr;
            mem_fault_d  = 1'b1;
            state_d      = FAULT;
          end else begin
            dm_req_d   = 1'b1;
            dm_we_d    = (opcode == OPCODE_ST);
            dm_addr_d  = {addr[31:2], 2'b00};
            dm_wdata_d = st_data;
            cnt_d      = 8'd0;
            state_d    = BUSY;
          end
        end
      end

      BUSY: begin
        if (dm_ack) begin
          dm_req_d = 1'b0;
          if (dm_err) begin
            fault_addr_d = dm_addr_q;
            mem_fault_d  = 1'b1;
            state_d      = FAULT;
          end else begin
            if (!dm_we_q) mem_out_d = dm_rdata;
            mem_valid_d = 1'b1;
            state_d     = IDLE;
          end
        end else if (cnt_inc == TIMEOUT_L) begin
          // Last cycle of the request window with no ack: abort.
          dm_req_d     = 1'b0;
          fault_addr_d = dm_addr_q;
          mem_fault_d  = 1'b1;
          state_d      = FAULT;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      dm_req_q     <= 1'b0;
      dm_we_q      <= 1'b0;
      dm_addr_q    <= 32'd0;
      dm_wdata_q   <= 32'd0;
      mem_out_q    <= 32'd0;
      mem_valid_q  <= 1'b0;
      mem_fault_q  <= 1'b0;
      fault_addr_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dm_req_q     <= dm_req_d;
      dm_we_q      <= dm_we_d;
      dm_addr_q    <= dm_addr_d;
      dm_wdata_q   <= dm_wdata_d;
      mem_out_q    <= mem_out_d;
      mem_valid_q  <= mem_valid_d;
      mem_fault_q  <= mem_fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign dm_req     = dm_req_q;
  assign dm_we      = dm_we_q;
  assign dm_addr    = dm_addr_q;
  assign dm_wdata   = dm_wdata_q;
  assign mem_out    = mem_out_q;
  assign mem_valid  = mem_valid_q;
  assign mem_fault  = mem_fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: hand-computed expectations per cycle,
// inputs driven and outputs sampled 1-2 time units after the rising edge.
module tb_mem_access;

  localparam logic [5:0] OP_LD  = 6'h23;
  localparam logic [5:0] OP_ST  = 6'h2b;
  localparam logic [5:0] OP_ADD = 6'h20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic        dm_err;
  logic [31:0] dm_rdata;
  logic        stall;
  logic [31:0] mem_out;
  logic        mem_valid;
  logic        mem_fault;
  logic [31:0] fault_addr;

  int total = 0;
  int bad   = 0;
  int req_hi;

  mem_access #(
    .TIMEOUT   (15),
    .OPCODE_LD (OP_LD),
    .OPCODE_ST (OP_ST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .opcode     (opcode),
    .addr       (addr),
    .st_data    (st_data),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_ack     (dm_ack),
    .dm_err     (dm_err),
    .dm_rdata   (dm_rdata),
    .stall      (stall),
    .mem_out    (mem_out),
    .mem_valid  (mem_valid),
    .mem_fault  (mem_fault),
    .fault_addr (fault_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance into the next cycle, just past the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] d);
    ex_valid = v;
    opcode   = op;
    addr     = a;
    st_data  = d;
  endtask

  task automatic mem_resp(input logic ack, input logic err, input logic [31:0] rd);
    dm_ack   = ack;
    dm_err   = err;
    dm_rdata = rd;
  endtask

  initial begin
    rst_n = 1'b0;
    present(1'b0, OP_ADD, 32'd0, 32'd0);
    mem_resp(1'b0, 1'b0, 32'd0);
    cyc();
    cyc();

    // Reset state; stall forced low even with an aligned LD presented.
    present(1'b1, OP_LD, 32'h100, 32'd0);
    #1;
    check("rst_stall", stall, 0);
    check("rst_dm_req", dm_req, 0);
    check("rst_dm_we", dm_we, 0);
    check("rst_dm_addr", dm_addr, 0);
    check("rst_dm_wdata", dm_wdata, 0);
    check("rst_mem_out", mem_out, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_fault", mem_fault, 0);
    check("rst_fault_addr", fault_addr, 0);
    present(1'b0, OP_ADD, 32'd0, 32'd0);
    rst_n = 1'b1;
    cyc();

    // LD 0x100, ack in the first request cycle.
    present(1'b1, OP_LD, 32'h100, 32'd0);
    #1;
    check("ld1_accept_stall", stall, 1);
    check("ld1_accept_req", dm_req, 0);
    cyc();
    mem_resp(1'b1, 1'b0, 32'hDEADBEEF);
    #1;
    check("ld1_req", dm_req, 1);
    check("ld1_addr", dm_addr, 32'h100);
    check("ld1_we", dm_we, 0);
    check("ld1_ack_stall", stall, 0);
    cyc();
    mem_resp(1'b0, 1'b0, 32'd0);
    present(1'b0, OP_ADD, 32'd0, 32'd0);
    #1;
    check("ld1_req_drop", dm_req, 0);
    check("ld1_valid", mem_valid, 1);
    check("ld1_mem_out", mem_out, 32'hDEADBEEF);
    cyc();
    check("ld1_valid_pulse", mem_valid, 0);

    // ST 0x12345678 @0x204, ack in the third request cycle.
    present(1'b1, OP_ST, 32'h204, 32'h12345678);
    #1;
    check("st_accept_stall", stall, 1);
    cyc();
    check("st_we", dm_we, 1);
    check("st_wdata", dm_wdata, 32'h12345678);
    check("st_addr", dm_addr, 32'h204);
    check("st_busy_stall1", stall, 1);
    cyc();
    check("st_busy_stall2", stall, 1);
    check("st_req_held", dm_req, 1);
    cyc();
    mem_resp(1'b1, 1'b0, 32'hCAFEF00D);
    #1;
    check("st_ack_stall", stall, 0);
    cyc();
    mem_resp(1'b0, 1'b0, 32'd0);
    present(1'b0, OP_ADD, 32'd0, 32'd0);
    #1;
    check("st_valid", mem_valid, 1);
    check("st_mem_out_kept", mem_out, 32'hDEADBEEF);
    check("st_req_drop", dm_req, 0);
    cyc();

    // Misaligned LD 0x103.
    present(1'b1, OP_LD, 32'h103, 32'd0);
    #1;
    check("mis_stall", stall, 0);
    cyc();
    present(1'b0, OP_ADD, 32'd0, 32'd0);
    #1;
    check("mis_no_req", dm_req, 0);
    check("mis_fault", mem_fault, 1);
    check("mis_fault_addr", fault_addr, 32'h103);
    cyc();
    check("mis_fault_pulse", mem_fault, 0);

    // Timeout on LD 0x40: request window of exactly 15 cycles.
    present(1'b1, OP_LD, 32'h40, 32'd0);
    req_hi = 0;
    for (int i = 1; i <= 15; i++) begin
      cyc();
      if (dm_req) req_hi++;
      if (i == 15) check("to_last_stall", stall, 1);
    end
    check("to_req_cycles", req_hi, 15);
    cyc();
    present(1'b0, OP_ADD, 32'd0, 32'd0);
    #1;
    check("to_req_drop", dm_req, 0);
    check("to_fault", mem_fault, 1);
    check("to_fault_addr", fault_addr, 32'h40);
    cyc();
    cyc();
    mem_resp(1'b1, 1'b0, 32'hBAD0BAD0);
    #1;
    check("late_ack_stall", stall, 0);
    cyc();
    mem_resp(1'b0, 1'b0, 32'd0);
    check("late_ack_no_valid", mem_valid, 0);
    check("late_ack_mem_out", mem_out, 32'hDEADBEEF);

    // Bus error on LD 0x80.
    present(1'b1, OP_LD, 32'h80, 32'd0);
    cyc();
    mem_resp(1'b1, 1'b1, 32'h55555555);
    cyc();
    mem_resp(1'b0, 1'b0, 32'd0);
    present(1'b0, OP_ADD, 32'd0, 32'd0);
    #1;
    check("err_fault", mem_fault, 1);
    check("err_fault_addr", fault_addr, 32'h80);
    check("err_mem_out", mem_out, 32'hDEADBEEF);
    check("err_no_valid", mem_valid, 0);
    cyc();

    // Ack in the same cycle the window expires wins over the timeout.
    present(1'b1, OP_LD, 32'h44, 32'd0);
    for (int i = 1; i <= 14; i++) cyc();
    cyc();
    mem_resp(1'b1, 1'b0, 32'h00000077);
    #1;
    check("edge_ack_stall", stall, 0);
    cyc();
    mem_resp(1'b0, 1'b0, 32'd0);
    present(1'b0, OP_ADD, 32'd0, 32'd0);
    #1;
    check("edge_valid", mem_valid, 1);
    check("edge_no_fault", mem_fault, 0);
    check("edge_mem_out", mem_out, 32'h77);
    cyc();

    // Reset during BUSY, then an ack right after is ignored.
    present(1'b1, OP_LD, 32'h200, 32'd0);
    cyc();
    check("rb_req", dm_req, 1);
    rst_n = 1'b0;
    cyc();
    present(1'b0, OP_ADD, 32'd0, 32'd0);
    #1;
    check("rb_req_drop", dm_req, 0);
    check("rb_stall", stall, 0);
    check("rb_dm_addr", dm_addr, 0);
    check("rb_mem_out", mem_out, 0);
    check("rb_fault_addr", fault_addr, 0);
    rst_n = 1'b1;
    mem_resp(1'b1, 1'b0, 32'h11111111);
    cyc();
    mem_resp(1'b0, 1'b0, 32'd0);
    check("rb_ack_ignored", mem_valid, 0);
    check("rb_ack_mem_out", mem_out, 0);

    // Non-memory opcode passes straight through.
    present(1'b1, OP_ADD, 32'h100, 32'd0);
    #1;
    check("add_stall", stall, 0);
    cyc();
    present(1'b0, OP_ADD, 32'd0, 32'd0);
    check("add_no_req", dm_req, 0);
    check("add_no_valid", mem_valid, 0);

    // Back-to-back LD 0x300 then ST 0x304.
    present(1'b1, OP_LD, 32'h300, 32'd0);
    cyc();
    mem_resp(1'b1, 1'b0, 32'hA5A5A5A5);
    cyc();
    mem_resp(1'b0, 1'b0, 32'd0);
    present(1'b1, OP_ST, 32'h304, 32'h0F0F0F0F);
    #1;
    check("b2b_ld_valid", mem_valid, 1);
    check("b2b_ld_out", mem_out, 32'hA5A5A5A5);
    check("b2b_st_accept", stall, 1);
    cyc();
    mem_resp(1'b1, 1'b0, 32'hEEEEEEEE);
    #1;
    check("b2b_st_req", dm_req, 1);
    check("b2b_st_we", dm_we, 1);
    check("b2b_st_addr", dm_addr, 32'h304);
    check("b2b_st_wdata", dm_wdata, 32'h0F0F0F0F);
    cyc();
    mem_resp(1'b0, 1'b0, 32'd0);
    present(1'b0, OP_ADD, 32'd0, 32'd0);
    #1;
    check("b2b_st_valid", mem_valid, 1);
    check("b2b_st_out_kept", mem_out, 32'hA5A5A5A5);
    check("b2b_req_drop", dm_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
